// File: rtl/emissor_msi_n.sv
// emissor_msi_n: requester-side MSI controller for a direct-mapped cache (optional snoop port: SNOOP_INV_EN)
module emissor_msi_n #(
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              alternar,
    input  logic              cpu_valid,
    input  logic              cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic              cpu_hit,
    output logic [1:0]        line_state,
    output logic              bus_req,
    output logic [1:0]        bus_msg,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wb,
`ifdef SNOOP_INV_EN
    input  logic              snoop_valid,
    input  logic [1:0]        snoop_msg,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              snoop_ready,
    output logic              snoop_wb,
`endif
    input  logic              bus_ack
);
    localparam int NUM_LINES = 2 ** IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_E = 2'b10;
    localparam logic [1:0] MSG_RD = 2'b01;
    localparam logic [1:0] MSG_WR = 2'b10;
    localparam logic [1:0] MSG_INV = 2'b11;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, BUS, RESP} fsm_t;

    fsm_t              fsm;
    logic [TAG_W-1:0]  tags [NUM_LINES];
    logic [1:0]        states [NUM_LINES];
    logic              req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              hit_r;
    logic [1:0]        msg_r;
    logic              cpu_hit_r;
    logic [1:0]        line_state_r;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic [1:0]        lk_state;
    logic              lk_hit;
    logic [1:0]        fill;

    assign idx      = req_addr[IDX_W-1:0];
    assign req_tag  = req_addr[ADDR_W-1:IDX_W];
    assign lk_state = states[idx];
    assign lk_hit   = (lk_state != ST_I) && (tags[idx] == req_tag);
    assign fill     = (msg_r == MSG_RD) ? ST_S : ST_E;

    assign cpu_ready  = Rst_n && (fsm == IDLE) && !alternar;
    assign cpu_done   = (fsm == RESP);
    assign cpu_hit    = cpu_hit_r;
    assign line_state = line_state_r;
    assign bus_req    = (fsm == WB) || (fsm == BUS);
    assign bus_wb     = (fsm == WB);
    assign bus_msg    = (fsm == BUS) ? msg_r : 2'b00;
    assign bus_addr   = (fsm == WB) ? {tags[idx], idx} : (fsm == BUS) ? req_addr : '0;

`ifdef SNOOP_INV_EN
    logic [IDX_W-1:0] s_idx;
    logic [TAG_W-1:0] s_tag;
    logic             s_hit;

    assign snoop_ready = Rst_n && (fsm != LOOKUP) && (fsm != RESP);
    assign s_idx = snoop_addr[IDX_W-1:0];
    assign s_tag = snoop_addr[ADDR_W-1:IDX_W];
    assign s_hit = snoop_valid && snoop_ready && (snoop_msg != 2'b00)
                   && (states[s_idx] != ST_I) && (tags[s_idx] == s_tag);
`endif

    // Request FSM, line directory and snoop downgrades; own fills take priority over a same-edge snoop
    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fsm          <= IDLE;
            req_op       <= 1'b0;
            req_addr     <= '0;
            hit_r        <= 1'b0;
            msg_r        <= 2'b00;
            cpu_hit_r    <= 1'b0;
            line_state_r <= ST_I;
            for (int i = 0; i < NUM_LINES; i++) begin
                tags[i]   <= '0;
                states[i] <= ST_I;
            end
`ifdef SNOOP_INV_EN
            snoop_wb     <= 1'b0;
`endif
        end else begin
`ifdef SNOOP_INV_EN
            snoop_wb <= s_hit && (states[s_idx] == ST_E);
            if (s_hit)
                states[s_idx] <= (snoop_msg == MSG_RD) ? ST_S : ST_I;
`endif
            case (fsm)
                IDLE: begin
                    if (cpu_valid && cpu_ready) begin
                        req_op   <= cpu_op;
                        req_addr <= cpu_addr;
                        fsm      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_r <= lk_hit;
                    msg_r <= (lk_hit && req_op) ? MSG_INV : req_op ? MSG_WR : MSG_RD;
                    if (lk_hit && (!req_op || lk_state == ST_E)) begin
                        cpu_hit_r    <= 1'b1;
                        line_state_r <= lk_state;
                        fsm          <= RESP;
                    end else if (!lk_hit && lk_state == ST_E) begin
                        fsm <= WB;
                    end else begin
                        fsm <= BUS;
                    end
                end
                WB: begin
                    if (bus_ack)
                        fsm <= BUS;
                end
                BUS: begin
                    if (bus_ack) begin
                        tags[idx]    <= req_tag;
                        states[idx]  <= fill;
                        cpu_hit_r    <= hit_r;
                        line_state_r <= fill;
                        fsm          <= RESP;
                    end
                end
                RESP: fsm <= IDLE;
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_emissor_msi_n.sv
// tb_emissor_msi_n: directed test of the MSI requester controller
module tb_emissor_msi_n;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       alternar;
    logic       cpu_valid;
    logic       cpu_op;
    logic [7:0] cpu_addr;
    logic       cpu_ready;
    logic       cpu_done;
    logic       cpu_hit;
    logic [1:0] line_state;
    logic       bus_req;
    logic [1:0] bus_msg;
    logic [7:0] bus_addr;
    logic       bus_wb;
    logic       bus_ack;
`ifdef SNOOP_INV_EN
    logic       snoop_valid;
    logic [1:0] snoop_msg;
    logic [7:0] snoop_addr;
    logic       snoop_ready;
    logic       snoop_wb;
`endif
    int n_chk = 0;
    int n_pass = 0;

    emissor_msi_n #(.ADDR_W(8), .IDX_W(2)) dut (
        .Clk(clk),
        .Rst_n(rst_n),
        .alternar(alternar),
        .cpu_valid(cpu_valid),
        .cpu_op(cpu_op),
        .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready),
        .cpu_done(cpu_done),
        .cpu_hit(cpu_hit),
        .line_state(line_state),
        .bus_req(bus_req),
        .bus_msg(bus_msg),
        .bus_addr(bus_addr),
        .bus_wb(bus_wb),
`ifdef SNOOP_INV_EN
        .snoop_valid(snoop_valid),
        .snoop_msg(snoop_msg),
        .snoop_addr(snoop_addr),
        .snoop_ready(snoop_ready),
        .snoop_wb(snoop_wb),
`endif
        .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
    endtask

    task automatic req(input logic op, input logic [7:0] addr);
        cpu_valid = 1'b1;
        cpu_op    = op;
        cpu_addr  = addr;
        cyc();
        cpu_valid = 1'b0;
    endtask

    task automatic ack();
        bus_ack = 1'b1;
        cyc();
        bus_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; alternar = 1'b0; cpu_valid = 1'b0; cpu_op = 1'b0;
        cpu_addr = 8'h00; bus_ack = 1'b0;
`ifdef SNOOP_INV_EN
        snoop_valid = 1'b0; snoop_msg = 2'b00; snoop_addr = 8'h00;
`endif
        cyc(); cyc();
        check("rst_ready", cpu_ready, 0);
        check("rst_done", cpu_done, 0);
        check("rst_busreq", bus_req, 0);
        check("rst_ls", line_state, 0);
        rst_n = 1'b1;
        cyc();
        check("idle_ready", cpu_ready, 1);

        // 1: read miss 0x15
        req(1'b0, 8'h15);
        check("t1_lookup_busreq", bus_req, 0);
        cyc();
        check("t1_busreq", bus_req, 1);
        check("t1_msg", bus_msg, 2'b01);
        check("t1_addr", bus_addr, 8'h15);
        check("t1_wb", bus_wb, 0);
        cyc(); cyc();
        check("t1_wait_busreq", bus_req, 1);
        check("t1_wait_done", cpu_done, 0);
        ack();
        check("t1_done", cpu_done, 1);
        check("t1_hit", cpu_hit, 0);
        check("t1_ls", line_state, 2'b01);
        check("t1_busreq_drop", bus_req, 0);
        cyc();
        check("t1_done_pulse", cpu_done, 0);
        check("t1_ls_hold", line_state, 2'b01);

        // 2: write hit S -> invalidate
        req(1'b1, 8'h15);
        cyc();
        check("t2_msg", bus_msg, 2'b11);
        check("t2_addr", bus_addr, 8'h15);
        check("t2_wb", bus_wb, 0);
        ack();
        check("t2_done", cpu_done, 1);
        check("t2_hit", cpu_hit, 1);
        check("t2_ls", line_state, 2'b10);
        cyc();

        // 3: read hit E, no bus
        req(1'b0, 8'h15);
        check("t3_lookup_done", cpu_done, 0);
        check("t3_lookup_busreq", bus_req, 0);
        cyc();
        check("t3_done", cpu_done, 1);
        check("t3_hit", cpu_hit, 1);
        check("t3_busreq", bus_req, 0);
        check("t3_ls", line_state, 2'b10);
        cyc();

        // 4: write 0x25 evicts E victim 0x15
        req(1'b1, 8'h25);
        cyc();
        check("t4_wb_req", bus_req, 1);
        check("t4_wb", bus_wb, 1);
        check("t4_wb_msg", bus_msg, 2'b00);
        check("t4_wb_addr", bus_addr, 8'h15);
        ack();
        check("t4_bus_req", bus_req, 1);
        check("t4_bus_wb", bus_wb, 0);
        check("t4_bus_msg", bus_msg, 2'b10);
        check("t4_bus_addr", bus_addr, 8'h25);
        ack();
        check("t4_done", cpu_done, 1);
        check("t4_hit", cpu_hit, 0);
        check("t4_ls", line_state, 2'b10);
        cyc();

        // 5: alternar hold, then reset in BUS
        alternar = 1'b1; cpu_valid = 1'b1; cpu_op = 1'b0; cpu_addr = 8'h06;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t5_hold_ready", cpu_ready, 0);
            check("t5_hold_busreq", bus_req, 0);
        end
        alternar = 1'b0;
        cyc();
        cpu_valid = 1'b0;
        cyc();
        check("t5_busreq", bus_req, 1);
        check("t5_msg", bus_msg, 2'b01);
        check("t5_addr", bus_addr, 8'h06);
        cyc();
        rst_n = 1'b0;
        #1;
        check("t5_rst_busreq", bus_req, 0);
        check("t5_rst_ready", cpu_ready, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("t5_post_ls", line_state, 0);
        req(1'b0, 8'h25);
        cyc();
        check("t5_miss_msg", bus_msg, 2'b01);
        check("t5_miss_addr", bus_addr, 8'h25);
        ack();
        check("t5_hit", cpu_hit, 0);
        check("t5_ls", line_state, 2'b01);
        cyc();

`ifdef SNOOP_INV_EN
        // 6: snoop writeMiss invalidates an E line
        req(1'b1, 8'h25);
        check("t6_lookup_sready", snoop_ready, 0);
        cyc();
        check("t6_inv_msg", bus_msg, 2'b11);
        ack();
        check("t6_ls", line_state, 2'b10);
        check("t6_resp_sready", snoop_ready, 0);
        cyc();
        check("t6_idle_sready", snoop_ready, 1);
        snoop_valid = 1'b1; snoop_msg = 2'b10; snoop_addr = 8'h25;
        cyc();
        snoop_valid = 1'b0;
        check("t6_swb", snoop_wb, 1);
        cyc();
        check("t6_swb_pulse", snoop_wb, 0);
        req(1'b0, 8'h25);
        cyc();
        check("t6_miss_msg", bus_msg, 2'b01);
        ack();
        check("t6_hit", cpu_hit, 0);
        check("t6_ls2", line_state, 2'b01);
        cyc();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
